wb_sram_bridge: RTL and testbench

Wishbone-classic slave that gives the Caravel management SoC access to port 0 (RW) of the 32x256 1RW1R program/data SRAM macro, so firmware can load and inspect memory. Port 1 (R) stays with the Patmos core. A core-run lock blocks host writes while the core executes and counts the dropped writes in a status register.

---
 rtl/wb_sram_pkg.sv | 22 ++
 rtl/wb_sram_bridge_if.sv | 26 ++
 rtl/wb_sram_bridge.sv | 175 +++++++++++++++++
 tb/tb_wb_sram_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sram_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM bridge.
package wb_sram_pkg;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } bridge_state_e;

    // Window offsets: SRAM occupies 0x000..0x3FF, STATUS sits at 0x400.
    localparam logic [11:0] OFF_STATUS   = 12'h400;
    localparam logic [11:0] SRAM_WIN_END = 12'h3FF;

    // Default Wishbone base of the 4 KiB window.
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

    // Width of the dropped-write counter reported in STATUS.
    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/wb_sram_bridge_if.sv
// Wishbone-classic slave bus bundle between the management SoC and the bridge.
interface wb_sram_bridge_if #(
    parameter int DW         = 32,
    parameter int NUM_WMASKS = 4
);
    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic                  wbs_we_i;
    logic [NUM_WMASKS-1:0] wbs_sel_i;
    logic [31:0]           wbs_adr_i;
    logic [DW-1:0]         wbs_dat_i;
    logic                  wbs_ack_o;
    logic [DW-1:0]         wbs_dat_o;

    // Bus master (management SoC side).
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    // Bus slave (bridge side).
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_sram_bridge.sv
// Wishbone-classic slave giving the management SoC access to SRAM port 0.
// Host writes are dropped (and counted) while the core runs; the count and
// the run flag are visible through the STATUS word.
module wb_sram_bridge
    import wb_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK  = 32'hFFFF_F000,
    parameter int          SRAM_AW    = 8,
    parameter int          DW         = 32,
    parameter int          NUM_WMASKS = 4
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_sram_bridge_if.slave       wbs,
    input  logic                  core_run_i,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [SRAM_AW-1:0]    sram_addr0,
    output logic [DW-1:0]         sram_din0,
    input  logic [DW-1:0]         sram_dout0
);

    bridge_state_e         state_q, state_d;
    logic                  we_q, we_d;
    logic                  ack_q, ack_d;
    logic [DW-1:0]         dat_q, dat_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
    logic [SRAM_AW-1:0]    addr0_q, addr0_d;
    logic [DW-1:0]         din0_q, din0_d;

    logic                  req;
    logic [11:0]           offset;
    logic                  is_sram;
    logic                  is_status;
    logic                  drop_inc;
    logic                  drop_clr;
    logic [DW-1:0]         status_word;

    assign req       = wbs.wbs_cyc_i && wbs.wbs_stb_i
                       && ((wbs.wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign offset    = wbs.wbs_adr_i[11:0];
    assign is_sram   = (offset <= SRAM_WIN_END);
    assign is_status = (offset == OFF_STATUS);

    // STATUS word: dropped-write count in the low half, live run flag above it.
    always_comb begin
        status_word                 = '0;
        status_word[DROP_CNT_W-1:0] = drop_cnt_q;
        status_word[DROP_CNT_W]     = core_run_i;
    end

    // Sequencer: accept in IDLE, drive SRAM for one ISSUE cycle, capture read
    // data in WAIT, acknowledge in ACK; a dropped cyc abandons the ack only.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        ack_d     = 1'b0;
        dat_d     = dat_q;
        csb0_d    = 1'b1;
        web0_d    = 1'b1;
        wmask0_d  = '0;
        addr0_d   = addr0_q;
        din0_d    = din0_q;
        drop_inc  = 1'b0;
        drop_clr  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d = wbs.wbs_we_i;
                    if (is_sram) begin
                        state_d = ISSUE;
                        if (!wbs.wbs_we_i) begin
                            csb0_d  = 1'b0;
                            addr0_d = wbs.wbs_adr_i[SRAM_AW+1:2];
                        end else if (core_run_i) begin
                            drop_inc = 1'b1;
                        end else if (wbs.wbs_sel_i != '0) begin
                            csb0_d   = 1'b0;
                            web0_d   = 1'b0;
                            wmask0_d = wbs.wbs_sel_i;
                            addr0_d  = wbs.wbs_adr_i[SRAM_AW+1:2];
                            din0_d   = wbs.wbs_dat_i;
                        end
                    end else begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                        dat_d   = '0;
                        if (is_status) begin
                            if (wbs.wbs_we_i) begin
                                drop_clr = 1'b1;
                            end else begin
                                dat_d = status_word;
                            end
                        end
                    end
                end
            end
            ISSUE: begin
                if (!wbs.wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (we_q) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    dat_d   = '0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!wbs.wbs_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    dat_d   = sram_dout0;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        drop_cnt_d = drop_cnt_q;
        if (drop_clr) begin
            drop_cnt_d = '0;
        end else if (drop_inc && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // State, bus outputs, SRAM port registers and drop counter.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            drop_cnt_q <= '0;
            csb0_q     <= 1'b1;
            web0_q     <= 1'b1;
            wmask0_q   <= '0;
            addr0_q    <= '0;
            din0_q     <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            drop_cnt_q <= drop_cnt_d;
            csb0_q     <= csb0_d;
            web0_q     <= web0_d;
            wmask0_q   <= wmask0_d;
            addr0_q    <= addr0_d;
            din0_q     <= din0_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign sram_csb0     = csb0_q;
    assign sram_web0     = web0_q;
    assign sram_wmask0   = wmask0_q;
    assign sram_addr0    = addr0_q;
    assign sram_din0     = din0_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Self-checking bench for wb_sram_bridge: directed cases then random traffic,
// checked against a word-array reference of the SRAM and a saturating count.
module tb_wb_sram_bridge;

    logic        clk;
    logic        rst;
    logic        core_run;
    logic        sram_csb0;
    logic        sram_web0;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;

    int total;
    int bad;

    // Behavioural SRAM macro (port 0) and the bench's reference model.
    logic [31:0] sram_mem [0:255];
    logic [31:0] ref_mem  [0:255];
    logic [15:0] ref_drop;

    wb_sram_bridge_if #(.DW(32), .NUM_WMASKS(4)) wbs ();

    wb_sram_bridge dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs         (wbs.slave),
        .core_run_i  (core_run),
        .sram_csb0   (sram_csb0),
        .sram_web0   (sram_web0),
        .sram_wmask0 (sram_wmask0),
        .sram_addr0  (sram_addr0),
        .sram_din0   (sram_din0),
        .sram_dout0  (sram_dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro: captures port signals on the rising edge, read data registered.
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wmask0[b]) sram_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
                end
            end else begin
                sram_dout0 <= sram_mem[sram_addr0];
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One Wishbone access; records ack cycle (relative to the accepting edge)
    // and what the SRAM port did. Cycle budget bounds the wait for ack.
    task automatic apply_stimulus(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                                  input logic [31:0] dat, output int ack_cyc, output logic [31:0] rdata,
                                  output int csb_low, output int csb_first, output logic [7:0] s_addr,
                                  output logic [3:0] s_mask, output logic s_web);
        ack_cyc = 0; rdata = '0; csb_low = 0; csb_first = 0;
        s_addr = '0; s_mask = '0; s_web = 1'b1;
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = we;
        wbs.wbs_sel_i = sel;  wbs.wbs_adr_i = adr;  wbs.wbs_dat_i = dat;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (!sram_csb0) begin
                csb_low++;
                if (csb_first == 0) begin
                    csb_first = k; s_addr = sram_addr0; s_mask = sram_wmask0; s_web = sram_web0;
                end
            end
            if (wbs.wbs_ack_o && ack_cyc == 0) begin
                ack_cyc = k; rdata = wbs.wbs_dat_o;
                wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
            end
        end
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
    endtask

    // Run one access, derive expectations from the reference model, check, update model.
    task automatic run_op(input string tag, input logic we, input logic [3:0] sel,
                          input logic [31:0] adr, input logic [31:0] dat, output logic [31:0] rdata);
        int          ack_cyc, csb_low, csb_first;
        logic [7:0]  s_addr;
        logic [3:0]  s_mask;
        logic        s_web;
        int          exp_ack, exp_csb;
        logic [31:0] exp_data;
        logic [11:0] off;
        int          idx;
        logic        hit;
        hit = ((adr & 32'hFFFF_F000) == 32'h3000_0000);
        off = adr[11:0];
        idx = int'(off) / 4;
        exp_data = '0;
        exp_ack = 0; exp_csb = 0;
        if (!hit) begin
            exp_ack = 0;
        end else if (off < 12'h400) begin
            exp_ack = we ? 2 : 3;
            exp_csb = (!we || (!core_run && sel != 4'h0)) ? 1 : 0;
            if (!we) exp_data = ref_mem[idx];
        end else if (off == 12'h400) begin
            exp_ack = 1;
            if (!we) exp_data = {15'h0, core_run, ref_drop};
        end else begin
            exp_ack = 1;
        end

        apply_stimulus(we, sel, adr, dat, ack_cyc, rdata, csb_low, csb_first, s_addr, s_mask, s_web);

        check_output({tag, ".ack_cycle"}, ack_cyc, exp_ack);
        check_output({tag, ".csb_low_cycles"}, csb_low, exp_csb);
        if (exp_ack != 0) begin
            check_output({tag, ".dat_o"}, rdata, exp_data);
            check_output({tag, ".dat_o_hold"}, wbs.wbs_dat_o, exp_data);
        end
        if (exp_csb != 0) begin
            check_output({tag, ".csb_cycle"}, csb_first, 1);
            check_output({tag, ".addr0"}, {24'h0, s_addr}, idx);
            check_output({tag, ".wmask0"}, {28'h0, s_mask}, we ? {28'h0, sel} : 32'h0);
            check_output({tag, ".web0"}, {31'h0, s_web}, {31'h0, !we});
        end

        if (hit && off < 12'h400 && we) begin
            if (core_run) begin
                if (ref_drop != 16'hFFFF) ref_drop = ref_drop + 16'd1;
            end else begin
                for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
            end
        end
        if (hit && off == 12'h400 && we) ref_drop = '0;
    endtask

    initial begin
        logic [31:0] rd;
        int          seen_ack;
        total = 0; bad = 0; ref_drop = '0;
        for (int i = 0; i < 256; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end
        rst = 1'b1; core_run = 1'b0;
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
        wbs.wbs_sel_i = '0; wbs.wbs_adr_i = '0; wbs.wbs_dat_i = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        check_output("rst.ack", {31'h0, wbs.wbs_ack_o}, 32'h0);
        check_output("rst.dat_o", wbs.wbs_dat_o, 32'h0);
        check_output("rst.csb0", {31'h0, sram_csb0}, 32'h1);
        check_output("rst.web0", {31'h0, sram_web0}, 32'h1);
        check_output("rst.wmask0", {28'h0, sram_wmask0}, 32'h0);
        check_output("rst.addr0", {24'h0, sram_addr0}, 32'h0);
        check_output("rst.din0", sram_din0, 32'h0);
        rst = 1'b0;

        // Full-word write and readback.
        run_op("wr_deadbeef", 1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, rd);
        run_op("rd_deadbeef", 1'b0, 4'hF, 32'h3000_0010, 32'h0, rd);
        check_output("rd_deadbeef.const", rd, 32'hDEAD_BEEF);

        // Byte-lane write.
        run_op("wr_word7", 1'b1, 4'hF, 32'h3000_001C, 32'h1122_3344, rd);
        run_op("wr_byte0", 1'b1, 4'h1, 32'h3000_001C, 32'h0000_00AA, rd);
        run_op("rd_word7", 1'b0, 4'hF, 32'h3000_001C, 32'h0, rd);
        check_output("rd_word7.const", rd, 32'h1122_33AA);

        // sel==0 write leaves SRAM idle.
        run_op("wr_sel0", 1'b1, 4'h0, 32'h3000_001C, 32'hFFFF_FFFF, rd);

        // Core-run lock: drops counted, reads still served.
        core_run = 1'b1;
        run_op("lock_wr0", 1'b1, 4'hF, 32'h3000_001C, 32'h0BAD_0000, rd);
        run_op("lock_wr1", 1'b1, 4'hF, 32'h3000_001C, 32'h0BAD_0001, rd);
        run_op("lock_wr2", 1'b1, 4'h3, 32'h3000_001C, 32'h0BAD_0002, rd);
        run_op("lock_rd", 1'b0, 4'hF, 32'h3000_001C, 32'h0, rd);
        check_output("lock_rd.const", rd, 32'h1122_33AA);
        run_op("status_rd", 1'b0, 4'hF, 32'h3000_0400, 32'h0, rd);
        check_output("status_rd.const", rd, 32'h0001_0003);
        run_op("status_clr", 1'b1, 4'hF, 32'h3000_0400, 32'h0, rd);
        run_op("status_rd2", 1'b0, 4'hF, 32'h3000_0400, 32'h0, rd);
        check_output("status_rd2.const", rd, 32'h0001_0000);

        // Saturation at 0xFFFF, then clear.
        @(negedge clk);
        dut.drop_cnt_q = 16'hFFFE;
        ref_drop = 16'hFFFE;
        run_op("sat_wr0", 1'b1, 4'hF, 32'h3000_0020, 32'h1, rd);
        run_op("sat_rd0", 1'b0, 4'hF, 32'h3000_0400, 32'h0, rd);
        check_output("sat_rd0.const", rd, 32'h0001_FFFF);
        run_op("sat_wr1", 1'b1, 4'hF, 32'h3000_0020, 32'h2, rd);
        run_op("sat_rd1", 1'b0, 4'hF, 32'h3000_0400, 32'h0, rd);
        check_output("sat_rd1.const", rd, 32'h0001_FFFF);
        run_op("sat_clr", 1'b1, 4'hF, 32'h3000_0400, 32'h0, rd);
        core_run = 1'b0;
        run_op("sat_rd2", 1'b0, 4'hF, 32'h3000_0400, 32'h0, rd);
        check_output("sat_rd2.const", rd, 32'h0000_0000);

        // Unmapped offsets and out-of-window accesses.
        run_op("pre_unmap", 1'b0, 4'hF, 32'h3000_0010, 32'h0, rd);
        run_op("unmap_rd", 1'b0, 4'hF, 32'h3000_0800, 32'h0, rd);
        check_output("unmap_rd.const", rd, 32'h0);
        run_op("unmap_wr", 1'b1, 4'hF, 32'h3000_0404, 32'h1234_5678, rd);
        run_op("miss_wr", 1'b1, 4'hF, 32'h3100_0010, 32'h5A5A_5A5A, rd);
        run_op("miss_rd", 1'b0, 4'hF, 32'h3100_0000, 32'h0, rd);
        run_op("post_miss", 1'b0, 4'hF, 32'h3000_0010, 32'h0, rd);
        check_output("post_miss.const", rd, 32'hDEAD_BEEF);

        // Abort: cyc dropped during WAIT.
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b0;
        wbs.wbs_sel_i = 4'hF; wbs.wbs_adr_i = 32'h3000_0010;
        @(negedge clk);
        check_output("abort.csb_issue", {31'h0, sram_csb0}, 32'h0);
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
        seen_ack = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (wbs.wbs_ack_o) seen_ack = 1;
        end
        check_output("abort.no_ack", seen_ack, 0);
        run_op("abort_status", 1'b0, 4'hF, 32'h3000_0400, 32'h0, rd);

        // Reset asserted while in ISSUE.
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b1;
        wbs.wbs_sel_i = 4'hF; wbs.wbs_adr_i = 32'h3000_0010; wbs.wbs_dat_i = 32'h5555_5555;
        @(negedge clk);
        check_output("rst_issue.csb_before", {31'h0, sram_csb0}, 32'h0);
        rst = 1'b1;
        #1;
        check_output("rst_issue.csb", {31'h0, sram_csb0}, 32'h1);
        check_output("rst_issue.ack", {31'h0, wbs.wbs_ack_o}, 32'h0);
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
        rst = 1'b0;
        ref_drop = '0;
        run_op("rst_issue.rd", 1'b0, 4'hF, 32'h3000_0010, 32'h0, rd);
        check_output("rst_issue.rd_const", rd, 32'hDEAD_BEEF);

        // Random traffic against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] adr;
            logic        we;
            core_run = ($urandom_range(0, 3) == 0);
            we = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 9))
                0:       adr = 32'h3000_0400;
                1:       adr = 32'h3000_0000 | ($urandom_range(0, 255) << 4) | 32'h0000_0400;
                default: adr = 32'h3000_0000 | ($urandom_range(0, 15) << 2);
            endcase
            run_op($sformatf("rand%0d", n), we, 4'($urandom), adr, $urandom, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
